// File: rtl/dust_pulse_encoder_pkg.sv
// Shared protocol constants and encodings for the dust pulse-position link.
// Frame: preamble pulses, N_BITS data symbols MSB first, trailer pulses.
// Each pulse is one high cycle followed by a gap of low cycles.
package dust_pulse_encoder_pkg;

  localparam int N_BITS       = 4;
  localparam int PRE_PULSES   = 3;
  localparam int TRAIL_PULSES = 2;
  localparam int SHORT_GAP    = 3;
  localparam int LONG_GAP     = 7;
  localparam int SEP_GAP      = 1;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Gap counter must hold LONG_GAP-1; sized to LONG_GAP+1 for headroom.
  localparam int GAP_W = $clog2(LONG_GAP + 1);
  // Pulse counter indexes preamble/trailer pulses and the three pulses of a bit symbol.
  localparam int CNT_W = $clog2(max_of(max_of(PRE_PULSES, TRAIL_PULSES), 3));
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  // Timer is loaded with gap-1 and the gap ends on the cycle it reads zero.
  localparam logic [GAP_W-1:0] SHORT_LOAD = GAP_W'(SHORT_GAP - 1);
  localparam logic [GAP_W-1:0] LONG_LOAD  = GAP_W'(LONG_GAP - 1);
  localparam logic [GAP_W-1:0] SEP_LOAD   = GAP_W'(SEP_GAP - 1);

  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_PULSES - 1);
  localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_PULSES - 1);
  localparam logic [IDX_W-1:0] BIT_FIRST  = IDX_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_BIT   = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_HIGH = 2'd0,
    PH_GAP1 = 2'd1,
    PH_GAP2 = 2'd2,
    PH_SEP  = 2'd3
  } phase_t;

endpackage

// File: rtl/dust_pulse_encoder_pulse_gap_timer.sv
// Load / count-down / zero-flag timer used for every low gap of the stream.
// Ports:
//   clk, srst   clock and synchronous active-high reset
//   load        load count with load_val this cycle (takes priority over counting)
//   load_val    value loaded (gap length minus one)
//   zero        high while the count is zero
module dust_pulse_encoder_pulse_gap_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/dust_pulse_encoder.sv
// Serialises an N_BITS amplitude word into a single-wire pulse-position stream:
// preamble pulses, one three-pulse symbol per bit (MSB first), trailer pulses.
// A '1' symbol has gaps (long, short), a '0' symbol has gaps (short, long).
// Ports:
//   CLK_IN    clock, all logic on posedge
//   rst       synchronous active-high reset; aborts a frame without done
//   start     frame request, sampled only while busy is low
//   amp_in    amplitude word, latched on the accepted start
//   busy      high from the cycle after accept through the last low cycle
//   done      one-cycle pulse right after busy falls
//   DATA_OUT  registered pulse stream
module dust_pulse_encoder
  import dust_pulse_encoder_pkg::*;
(
  input  logic              CLK_IN,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] amp_in,
  output logic              busy,
  output logic              done,
  output logic              DATA_OUT
);

  if (!(SHORT_GAP >= 1 && SHORT_GAP < LONG_GAP && SEP_GAP >= 1)) begin : g_gap_check
    $error("dust_pulse_encoder: gap constants must satisfy 1 <= SHORT_GAP < LONG_GAP and SEP_GAP >= 1");
  end

  state_t            state_reg, state_next;
  phase_t            phase_reg, phase_next;
  logic [CNT_W-1:0]  pulse_cnt_reg, pulse_cnt_next;
  logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [N_BITS-1:0] amp_q_reg, amp_q_next;
  logic              data_reg, data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              timer_load;
  logic [GAP_W-1:0]  timer_val;
  logic              timer_zero;

  dust_pulse_encoder_pulse_gap_timer #(.W(GAP_W)) u_timer (
    .clk      (CLK_IN),
    .srst     (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= PH_HIGH;
      pulse_cnt_reg <= '0;
      bit_idx_reg   <= '0;
      amp_q_reg     <= '0;
      data_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      pulse_cnt_reg <= pulse_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      amp_q_reg     <= amp_q_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  // state/phase describe what DATA_OUT shows this cycle; the *_next values
  // decide the following cycle, which keeps DATA_OUT a plain register.
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    pulse_cnt_next = pulse_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    amp_q_next     = amp_q_reg;
    data_next      = data_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    timer_load     = 1'b0;
    timer_val      = '0;

    if (state_reg == ST_IDLE) begin
      if (start) begin
        amp_q_next     = amp_in;
        busy_next      = 1'b1;
        data_next      = 1'b1;
        state_next     = ST_PRE;
        phase_next     = PH_HIGH;
        pulse_cnt_next = '0;
      end
    end else begin
      case (phase_reg)
        PH_HIGH: begin
          // Every pulse is one cycle; pick the gap that follows it.
          data_next  = 1'b0;
          timer_load = 1'b1;
          phase_next = PH_SEP;
          timer_val  = SEP_LOAD;
          if (state_reg == ST_BIT) begin
            if (pulse_cnt_reg == CNT_W'(0)) begin
              phase_next = PH_GAP1;
              timer_val  = amp_q_reg[bit_idx_reg] ? LONG_LOAD : SHORT_LOAD;
            end else if (pulse_cnt_reg == CNT_W'(1)) begin
              phase_next = PH_GAP2;
              timer_val  = amp_q_reg[bit_idx_reg] ? SHORT_LOAD : LONG_LOAD;
            end
          end
        end
        PH_GAP1, PH_GAP2: begin
          if (timer_zero) begin
            data_next      = 1'b1;
            phase_next     = PH_HIGH;
            pulse_cnt_next = pulse_cnt_reg + 1'b1;
          end
        end
        default: begin  // PH_SEP
          if (timer_zero) begin
            data_next  = 1'b1;
            phase_next = PH_HIGH;
            case (state_reg)
              ST_PRE: begin
                if (pulse_cnt_reg == PRE_LAST) begin
                  state_next     = ST_BIT;
                  bit_idx_next   = BIT_FIRST;
                  pulse_cnt_next = '0;
                end else begin
                  pulse_cnt_next = pulse_cnt_reg + 1'b1;
                end
              end
              ST_BIT: begin
                pulse_cnt_next = '0;
                if (bit_idx_reg == '0) begin
                  state_next = ST_TRAIL;
                end else begin
                  bit_idx_next = bit_idx_reg - 1'b1;
                end
              end
              default: begin  // ST_TRAIL
                if (pulse_cnt_reg == TRAIL_LAST) begin
                  state_next     = ST_IDLE;
                  data_next      = 1'b0;
                  busy_next      = 1'b0;
                  done_next      = 1'b1;
                  pulse_cnt_next = '0;
                end else begin
                  pulse_cnt_next = pulse_cnt_reg + 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign DATA_OUT = data_reg;

endmodule

// File: tb/tb_dust_pulse_encoder.sv
module tb_dust_pulse_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] amp_in = '0;
  logic       busy, done, data_out;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];

  dust_pulse_encoder dut (
    .CLK_IN   (clk),
    .rst      (rst),
    .start    (start),
    .amp_in   (amp_in),
    .busy     (busy),
    .done     (done),
    .DATA_OUT (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, got, expv, $time);
    end
  endtask

  // Reference waveform straight from the frame rules: a pulse is one high
  // cycle followed by a number of low cycles.
  function automatic void add_pulse(input int low_cycles);
    exp_q.push_back(1'b1);
    for (int i = 0; i < low_cycles; i++) exp_q.push_back(1'b0);
  endfunction

  function automatic void build_frame(input logic [3:0] amp);
    exp_q.delete();
    for (int p = 0; p < 3; p++) add_pulse(1);
    for (int b = 3; b >= 0; b--) begin
      add_pulse(amp[b] ? 7 : 3);
      add_pulse(amp[b] ? 3 : 7);
      add_pulse(1);
    end
    for (int p = 0; p < 2; p++) add_pulse(1);
  endfunction

  task automatic idle_check(input int n, input string tag);
    repeat (n) begin
      tick();
      chk({tag, ".data"}, data_out, 1'b0);
      chk({tag, ".busy"}, busy, 1'b0);
      chk({tag, ".done"}, done, 1'b0);
    end
  endtask

  // Requests a frame in the current cycle and checks every cycle through the
  // done cycle. Returns without ticking past done so a following call starts
  // the next frame in the done cycle.
  task automatic run_frame(input logic [3:0] amp, input int repulse_at, input int abort_at);
    int len;
    int e0;
    build_frame(amp);
    len = exp_q.size();
    e0 = errors;
    start  = 1'b1;
    amp_in = amp;
    for (int k = 1; k <= len + 1; k++) begin
      tick();
      start = 1'b0;
      if (k == 1) amp_in = 4'($urandom);
      chk("frame.data", data_out, (k <= len) ? exp_q[k-1] : 1'b0);
      chk("frame.busy", busy, (k <= len));
      chk("frame.done", done, (k == len + 1));
      if (k == repulse_at) begin
        start  = 1'b1;
        amp_in = 4'b0100;
      end
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.data", data_out, 1'b0);
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        idle_check(80, "abort");
        $display("frame amp=%b aborted at cycle %0d errors_in_frame=%0d", amp, abort_at, errors - e0);
        return;
      end
    end
    $display("frame amp=%b len=%0d repulse=%0d errors_in_frame=%0d", amp, len, repulse_at, errors - e0);
  endtask

  initial begin
    // Reset held three cycles with start asserted: nothing may come out.
    rst    = 1'b1;
    start  = 1'b1;
    amp_in = 4'hF;
    repeat (3) begin
      tick();
      chk("reset.data", data_out, 1'b0);
      chk("reset.busy", busy, 1'b0);
      chk("reset.done", done, 1'b0);
    end
    rst   = 1'b0;
    start = 1'b0;
    idle_check(5, "post_reset");
    $display("reset check done errors=%0d", errors);

    // Frame length from the reference model must be 66 cycles.
    build_frame(4'b1011);
    checks++;
    assert (exp_q.size() == 66) else begin
      errors++;
      $error("FAIL model_len: observed=%0d expected=66", exp_q.size());
    end

    run_frame(4'b1011, -1, -1);
    idle_check(3, "gap");
    run_frame(4'b0000, -1, -1);
    idle_check(2, "gap");
    run_frame(4'b1111, -1, -1);
    idle_check(2, "gap");

    // Start re-pulsed mid-frame is ignored.
    run_frame(4'b1011, 20, -1);
    idle_check(2, "gap");

    // Random amplitudes, some back-to-back with start in the done cycle.
    for (int i = 0; i < 4; i++) begin
      run_frame(4'($urandom), -1, -1);
      if ($urandom_range(1, 0) == 1) idle_check(2, "gap");
    end
    run_frame(4'($urandom), -1, -1);
    run_frame(4'($urandom), -1, -1);
    idle_check(2, "gap");

    // Reset mid-frame aborts without done; a fresh frame is then clean.
    run_frame(4'($urandom), -1, 30);
    run_frame(4'b1011, -1, -1);
    idle_check(3, "tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
